ps2_keypad: RTL

PS/2 keyboard receiver and Chip-8 keypad decoder. Sits directly upstream of the chip8 core's keyboard input and replaces raw PS2KeyboardClk/PS2KeyboardData handling with a clean 16-bit key-state vector plus per-event strobes. It filters the open-collector PS/2 lines, deframes 11-bit device-to-host frames, tracks the F0 (break) and E0 (extended) prefixes, and maps scan-code set 2 onto the 4x4 hex keypad.

---
 rtl/ps2_keypad.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ps2_keypad.sv
// ps2_keypad: PS/2 set-2 receiver that decodes make/break events onto a Chip-8 4x4 hex keypad
module ps2_keypad #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_down,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_make,
  output logic        frame_error
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic filt, fall, timeout, err, done, flush, par, byte_rdy, brk, ext;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shift, byte_q;
  logic [4:0] hit;
  function automatic logic [4:0] map(input logic [7:0] b);
    case (b)
      8'h22: map = 5'h10;  8'h16: map = 5'h11;  8'h1E: map = 5'h12;  8'h26: map = 5'h13;
      8'h15: map = 5'h14;  8'h1D: map = 5'h15;  8'h24: map = 5'h16;  8'h1C: map = 5'h17;
      8'h1B: map = 5'h18;  8'h23: map = 5'h19;  8'h1A: map = 5'h1A;  8'h21: map = 5'h1B;
      8'h25: map = 5'h1C;  8'h2D: map = 5'h1D;  8'h2B: map = 5'h1E;  8'h2A: map = 5'h1F;
      default: map = 5'h00;
    endcase
  endfunction
  assign hit     = map(byte_q);
  assign fall    = filt && !clk_s[1] && fcnt == FW'(FILTER_LEN - 1);
  assign timeout = state != IDLE && tcnt == TW'(TIMEOUT);
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      filt  <= 1'b1;
      fcnt  <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      if (clk_s[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        fcnt <= '0;
      end else fcnt <= fcnt + FW'(1);
    end
  end
  always_comb begin
    state_n = state;
    err     = 1'b0;
    done    = 1'b0;
    flush   = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      err     = 1'b1;
      flush   = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (dat_s[1]) err = 1'b1; else state_n = DATA;
        DATA:   state_n = bcnt == 3'd7 ? PARITY : DATA;
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          done    = dat_s[1] && par;
          err     = !done;
          flush   = !done;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shift       <= '0;
      par         <= 1'b0;
      byte_rdy    <= 1'b0;
      byte_q      <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      frame_error <= err;
      byte_rdy    <= done;
      if (done) byte_q <= shift;
      tcnt <= (state == IDLE || fall) ? '0 : (tcnt == TW'(TIMEOUT) ? tcnt : tcnt + TW'(1));
      if (fall && state == IDLE) bcnt <= '0;
      if (fall && state == DATA) begin
        shift <= {dat_s[1], shift[7:1]};
        bcnt  <= bcnt + 3'd1;
      end
      if (fall && state == PARITY) par <= ^shift ^ dat_s[1];
    end
  end
  // Prefix flags persist across frames until a terminating byte or a broken frame.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      brk       <= 1'b0;
      ext       <= 1'b0;
      key_down  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_make  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (flush) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_rdy) begin
        if (byte_q == 8'hF0) brk <= 1'b1;
        else if (byte_q == 8'hE0) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext && hit[4]) begin
            key_valid          <= 1'b1;
            key_code           <= hit[3:0];
            key_make           <= !brk;
            key_down[hit[3:0]] <= !brk;
          end
        end
      end
    end
  end
endmodule
